// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory programming bus of the boot loader.
//   rx_valid/rx_data          : received byte stream (master -> loader)
//   prog_en/prog_addr/prog_data: instruction-memory write port (loader -> memory)
//   start/busy/err            : core release and load status (loader -> system)
interface prog_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        prog_en;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        start;
  logic        busy;
  logic        err;

  modport master (
    output rx_valid, rx_data,
    input  prog_en, prog_addr, prog_data, start, busy, err
  );

  modport slave (
    input  rx_valid, rx_data,
    output prog_en, prog_addr, prog_data, start, busy, err
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a length-prefixed, checksummed byte image,
// writes it word-by-word into instruction memory and then releases the core.
//   clk_i : system clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : prog_loader_if.slave (rx byte stream in; prog write port, start/busy/err out)
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic          clk_i,
  input  logic          rst_i,
  prog_loader_if.slave  bus
);

  localparam int unsigned WCW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_e;

  state_e          state_q;
  logic [7:0]      sum_q;
  logic [1:0]      byte_cnt_q;
  logic [WCW-1:0]  word_cnt_q;
  logic [WCW-1:0]  num_words_q;
  logic [23:0]     shift_q;
  logic            prog_en_q;
  logic [31:0]     prog_addr_q;
  logic [31:0]     prog_data_q;
  logic            start_q;
  logic            busy_q;
  logic            err_q;

  // Little-endian assembly: the newest byte lands on top, so after the 4th
  // byte of a field this is the complete 32-bit value.
  logic [31:0] shift_d;
  logic [7:0]  sum_d;
  assign shift_d = {bus.rx_data, shift_q};
  assign sum_d   = sum_q + bus.rx_data;

  // Loader FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_HDR;
      sum_q       <= 8'd0;
      byte_cnt_q  <= 2'd0;
      word_cnt_q  <= '0;
      num_words_q <= '0;
      shift_q     <= 24'd0;
      prog_en_q   <= 1'b0;
      prog_addr_q <= BASE_ADDR;
      prog_data_q <= 32'd0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prog_en_q <= 1'b0;
      if (bus.rx_valid) begin
        case (state_q)
          S_HDR: begin
            busy_q     <= 1'b1;
            sum_q      <= sum_d;
            shift_q    <= shift_d[31:8];
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              num_words_q <= WCW'(shift_d);
              word_cnt_q  <= '0;
              if (shift_d > 32'(MAX_WORDS)) begin
                state_q <= S_ERR;
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
              end else if (shift_d == 32'd0) begin
                state_q <= S_CSUM;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
          S_DATA: begin
            sum_q      <= sum_d;
            shift_q    <= shift_d[31:8];
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              prog_en_q   <= 1'b1;
              prog_addr_q <= BASE_ADDR + (32'(word_cnt_q) << 2);
              prog_data_q <= shift_d;
              word_cnt_q  <= word_cnt_q + WCW'(1);
              if (word_cnt_q == num_words_q - WCW'(1)) begin
                state_q <= S_CSUM;
              end
            end
          end
          S_CSUM: begin
            sum_q  <= sum_d;
            busy_q <= 1'b0;
            if (sum_d == 8'd0) begin
              state_q <= S_RUN;
              start_q <= 1'b1;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
          default: ; // S_RUN / S_ERR are terminal and ignore rx bytes
        endcase
      end
    end
  end

  assign bus.prog_en   = prog_en_q;
  assign bus.prog_addr = prog_addr_q;
  assign bus.prog_data = prog_data_q;
  assign bus.start     = start_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that drives the instruction-memory programming port (`prog_en`/`prog_addr`/`prog_data`) and the core `start` line. It takes a byte stream from a serial receiver, parses a length-prefixed image, writes it word-by-word into instruction memory, verifies a checksum, and only then releases the core by raising `start`. It sits at the top level between the UART receiver and the core.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first word written.
- `MAX_WORDS`, default 4096: largest accepted image size, in words.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_valid`  in  1  `rx_data` holds a new byte this cycle. At most one byte per cycle.
- `rx_data`  in  8  received byte.
- `prog_en`  out  1  one-cycle instruction-memory write strobe.
- `prog_addr`  out  32  byte address of the write; word-aligned.
- `prog_data`  out  32  write data.
- `start`  out  1  core run enable. Low holds the core in reset; stays high once set.
- `busy`  out  1  a load is in progress.
- `err`  out  1  sticky load error (size or checksum).

## Operation
- Image format, all multi-byte fields little-endian:
  - 4-byte word count N.
  - N payload words, 4 bytes each.
  - 1 checksum byte C.
  - Valid image: (sum of all header bytes + all payload bytes + C) mod 256 == 0.
- FSM states are S_HDR, S_DATA, S_CSUM, S_RUN and S_ERR. Reset state is S_HDR.
- **S_HDR**
  - Shifts in 4 bytes and adds each byte to an 8-bit running sum.
  - After the 4th byte:
    - N > MAX_WORDS: go to S_ERR.
    - N == 0: go to S_CSUM.
    - Otherwise: go to S_DATA.
- **S_DATA**
  - A 2-bit byte counter assembles each word; byte 0 goes to bits [7:0].
  - When the 4th byte of word i is accepted, the next cycle has:
    - `prog_en` = 1
    - `prog_addr` = BASE_ADDR + 4·i
    - `prog_data` = the assembled word
  - After word N−1 is written, go to S_CSUM.
  - The word counter is wide enough to hold MAX_WORDS.
- **S_CSUM**
  - On the next byte, go to S_RUN if the final sum is 0, otherwise go to S_ERR.
- **S_RUN**
  - `start` = 1. All rx bytes are ignored. Terminal until `rst`.
- **S_ERR**
  - `err` = 1 and `start` = 0. All rx bytes are ignored. Terminal until `rst`.
  - Words already written are not rolled back.
- `busy` is 1 from the first accepted header byte until the FSM enters S_RUN or S_ERR.
- Cycles with `rx_valid` = 0 change nothing: no timeouts, and gaps of any length are allowed.

## Timing
- Reset values:
  - `start` = 0, `prog_en` = 0, `prog_addr` = BASE_ADDR, `prog_data` = 0.
  - `busy` = 0, `err` = 0.
  - Running sum, byte counter and word counter are all 0.
- All outputs are registered.
- Write latency: `prog_en` rises exactly 1 cycle after the cycle that accepts the 4th byte of a word.
  - `prog_addr` and `prog_data` are valid in that same cycle.
  - Both hold their value until the next write.
- Back-to-back bytes every cycle give at most one `prog_en` per 4 cycles, so writes never collide.
- `start` and `err` rise 1 cycle after the deciding byte is accepted:
  - `err` after the 4th header byte or the checksum byte;
  - `start` after the checksum byte.
- The last `prog_en` always comes at least 1 cycle before `start` rises.
- `rst` asserted mid-load:
  - The next cycle shows the reset values and the FSM is in S_HDR.
  - Any partially assembled word is discarded and no `prog_en` is issued for it.
- `rst` wins over `rx_valid` when both are high in the same cycle.

## Test plan
- **Reset values:** hold `rst` for 2 cycles, then idle 10 cycles. All outputs stay at their reset values and `prog_en` never pulses.
- **Nominal 2-word load:** stream bytes 02 00 00 00 13 00 00 00 93 00 10 00 48 back-to-back, with BASE_ADDR = 0.
  - Exactly two `prog_en` pulses: (addr 0x0, data 0x00000013) and (addr 0x4, data 0x00100093).
  - `start` = 1 one cycle after byte 0x48.
  - `busy` falls when `start` rises; `err` stays 0.
- **Bad checksum:** same stream with final byte 0x49.
  - Both writes still occur.
  - `err` = 1 and `start` stays 0 permanently.
  - Further bytes are ignored.
- **Oversize image:** with MAX_WORDS = 4, send count bytes 05 00 00 00.
  - `err` = 1 one cycle after the 4th header byte.
  - Zero `prog_en` pulses.
- **Empty image:** send 00 00 00 00 00.
  - No `prog_en` pulses.
  - `start` = 1 one cycle after the 5th byte.
- **Gaps and reset mid-load:**
  - Random 0–5 cycle gaps between bytes in the 2-word image give the same writes as the nominal case.
  - `rst` asserted after the 6th byte gives no `prog_en` and returns to S_HDR.
  - Sending the full image again then loads it normally and raises `start`.
